codec_cfg_sequencer: RTL
========================

Name: codec_cfg_sequencer

Overview:
- Upstream feeder for the I2C write engine that drives FPGA_I2C_SCLK/SDAT.
- Walks a fixed WM8731 register table after reset. For each entry, presents one 3-byte write to the engine: chip address, then the two bytes of the 16-bit register word.
- Handles request/accept/done handshaking, NACK retries, inter-transaction gaps, and done/error status for top-level LEDs and audio-path enable.

Parameters:
- DEV_ADDR, 8'h34, I2C write address byte placed on tx_addr.
- NUM_REGS, 11, number of table entries sent, 1..11.
- PWR_WAIT, 50000, clk cycles idled after reset before the first write.
- GAP_CYCLES, 1000, clk cycles idled between consecutive writes.
- RETRY_MAX, 3, retries per entry after the first NACK.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- restart  in  1  one-cycle pulse; re-runs the whole table from DONE or ERROR, ignored otherwise.
- tx_req  out  1  write request to the I2C engine.
- tx_ack  in  1  engine accepted the request, one-cycle pulse.
- tx_addr  out  8  chip address byte.
- tx_data1  out  8  register word [15:8].
- tx_data2  out  8  register word [7:0].
- tx_done  in  1  transaction finished, one-cycle pulse.
- tx_nack  in  1  valid with tx_done; 1 = any ACK slot missed.
- busy  out  1  sequence in progress.
- cfg_done  out  1  all entries written.
- cfg_error  out  1  retries exhausted.
- reg_index  out  4  current table entry.

Behaviour:
- Reset values:
  - State POWER_WAIT.
  - tx_req=0; tx_addr/tx_data1/tx_data2=0.
  - busy=1, cfg_done=0, cfg_error=0, reg_index=0.
  - Delay counter=0, retry counter=0.
- Table, index -> word:
  - 0 0x1E00 (reset)
  - 1 0x0017
  - 2 0x0217
  - 3 0x0479
  - 4 0x0679
  - 5 0x0812
  - 6 0x0A00
  - 7 0x0C00
  - 8 0x0E42
  - 9 0x1000
  - 10 0x1201 (active)
- States:
  - POWER_WAIT: count to PWR_WAIT-1, then LOAD.
  - LOAD: register the table word for reg_index onto tx_data1/tx_data2; tx_addr=DEV_ADDR. -> REQ next cycle.
  - REQ: tx_req=1 and the data outputs held stable. On tx_ack, tx_req drops the following cycle -> WAIT_DONE.
  - WAIT_DONE: wait for tx_done.
    - tx_nack=0: clear retry counter -> GAP.
    - tx_nack=1 and retries<RETRY_MAX: retries+1 -> GAP, then re-issue the same index.
    - tx_nack=1 and retries==RETRY_MAX: -> ERROR.
  - GAP: count to GAP_CYCLES-1.
    - After a success: if reg_index==NUM_REGS-1 -> DONE, else reg_index+1 -> LOAD.
    - After a NACK: -> LOAD with the same index.
  - DONE: busy=0, cfg_done=1, tx_req=0.
  - ERROR: busy=0, cfg_error=1, tx_req=0. reg_index frozen at the failing entry.
- restart pulse in DONE or ERROR: clear flags, reg_index=0, retries=0, busy=1 -> LOAD. No power wait.
- Handshake rules:
  - tx_req never deasserts before tx_ack.
  - Data outputs stay unchanged from LOAD until tx_done is sampled.
  - tx_ack coincident with tx_done in REQ: treat as accepted and done in the same cycle; evaluate tx_nack that cycle.
  - tx_done outside WAIT_DONE (or REQ as above): ignored.
- Only one outstanding request at a time.
- reset asserted mid-transaction: immediate return to reset values. tx_req drops on the next edge. The engine must tolerate an abandoned request.
- Counters are sized to hold max(PWR_WAIT, GAP_CYCLES). PWR_WAIT or GAP_CYCLES of 0 is treated as 1.

Optional Feature:
- Macro: CFG_TIMEOUT_EN.
- With the macro: a 20-bit watchdog counts in REQ and WAIT_DONE and clears on state entry. Reaching 2^20-1 with no tx_ack/tx_done is handled exactly as tx_done with tx_nack=1 (retry or ERROR), and tx_req drops.
- Without the macro: the block waits indefinitely, and no watchdog logic is synthesised.

Test Plan:
- Reset, PWR_WAIT=10, GAP_CYCLES=4, engine model ACKs everything, 2 cycles accept, 20 cycles done -> 11 writes in table order, first tx_data1/tx_data2=0x1E/0x00, last 0x12/0x01, tx_addr=0x34 always; cfg_done=1, busy=0.
- Engine NACKs index 3 twice then ACKs -> index 3 (0x04/0x79) issued 3 times, sequence completes, cfg_error=0.
- Engine NACKs index 5 always, RETRY_MAX=3 -> exactly 4 attempts of 0x08/0x12, cfg_error=1, reg_index=5, tx_req=0.
- Engine delays tx_ack 50 cycles -> tx_req and all data bytes stable throughout, single write per entry.
- reset pulsed while in WAIT_DONE at index 7, then restart pulsed after cfg_done -> full re-run from index 0 in both cases, restart run skips the PWR_WAIT delay.
- CFG_TIMEOUT_EN defined, engine never acks -> after 2^20-1 cycles treated as NACK, 4 attempts then cfg_error=1.

Source files
------------

// File: rtl/codec_cfg_sequencer.sv
// codec_cfg_sequencer: walks the WM8731 register table after reset and feeds
// one 3-byte write per entry (chip address, word[15:8], word[7:0]) to the I2C
// write engine, with NACK retries, inter-write gaps and done/error status.
// Optional: define CFG_TIMEOUT_EN to add a 20-bit request/done watchdog.
module codec_cfg_sequencer #(
    parameter logic [7:0]  DEV_ADDR   = 8'h34,
    parameter int unsigned NUM_REGS   = 11,
    parameter int unsigned PWR_WAIT   = 50000,
    parameter int unsigned GAP_CYCLES = 1000,
    parameter int unsigned RETRY_MAX  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    output logic       tx_req,
    input  logic       tx_ack,
    output logic [7:0] tx_addr,
    output logic [7:0] tx_data1,
    output logic [7:0] tx_data2,
    input  logic       tx_done,
    input  logic       tx_nack,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_error,
    output logic [3:0] reg_index
);

    // Zero-length waits behave as a single cycle.
    localparam int unsigned PW_EFF   = (PWR_WAIT == 0) ? 1 : PWR_WAIT;
    localparam int unsigned GAP_EFF  = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;
    localparam int unsigned CNT_MAX  = (PW_EFF > GAP_EFF) ? PW_EFF : GAP_EFF;
    localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned RTY_W    = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [3:0]  LAST_IDX = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_POWER_WAIT,
        S_LOAD,
        S_REQ,
        S_WAIT_DONE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [RTY_W-1:0]   retry_q;
    logic               nack_q;       // last transaction ended in NACK
    logic [3:0]         reg_index_q;
    logic [7:0]         tx_addr_q, tx_data1_q, tx_data2_q;

    logic               txn_end;      // transaction completes this cycle
    logic               txn_fail;     // ... and it failed
    logic               retry_full;
    logic               pw_last, gap_last;
    logic               wd_expired;

    function automatic logic [15:0] table_word(input logic [3:0] idx);
        logic [15:0] w;
        unique case (idx)
            4'd0:    w = 16'h1E00;
            4'd1:    w = 16'h0017;
            4'd2:    w = 16'h0217;
            4'd3:    w = 16'h0479;
            4'd4:    w = 16'h0679;
            4'd5:    w = 16'h0812;
            4'd6:    w = 16'h0A00;
            4'd7:    w = 16'h0C00;
            4'd8:    w = 16'h0E42;
            4'd9:    w = 16'h1000;
            4'd10:   w = 16'h1201;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    assign retry_full = (retry_q == RTY_W'(RETRY_MAX));
    assign pw_last    = (cnt_q == CNT_W'(PW_EFF - 1));
    assign gap_last   = (cnt_q == CNT_W'(GAP_EFF - 1));

`ifdef CFG_TIMEOUT_EN
    logic [19:0] wd_q;

    assign wd_expired = (wd_q == '1);

    // Watchdog: runs while a request or its completion is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
        end else if (state_d != state_q) begin
            wd_q <= '0;
        end else if (state_q == S_REQ || state_q == S_WAIT_DONE) begin
            wd_q <= wd_q + 1'b1;
        end
    end
`else
    assign wd_expired = 1'b0;
`endif

    // Completion detection: done in WAIT_DONE, ack+done together in REQ,
    // or watchdog expiry, which is handled as a NACK.
    always_comb begin
        txn_end  = 1'b0;
        txn_fail = 1'b0;
        if (state_q == S_REQ) begin
            if (tx_ack && tx_done) begin
                txn_end  = 1'b1;
                txn_fail = tx_nack;
            end else if (!tx_ack && wd_expired) begin
                txn_end  = 1'b1;
                txn_fail = 1'b1;
            end
        end else if (state_q == S_WAIT_DONE) begin
            if (tx_done) begin
                txn_end  = 1'b1;
                txn_fail = tx_nack;
            end else if (wd_expired) begin
                txn_end  = 1'b1;
                txn_fail = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_POWER_WAIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_POWER_WAIT: if (pw_last) state_d = S_LOAD;
            S_LOAD:       state_d = S_REQ;
            S_REQ: begin
                if (txn_end) begin
                    state_d = (txn_fail && retry_full) ? S_ERROR : S_GAP;
                end else if (tx_ack) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (txn_end) begin
                    state_d = (txn_fail && retry_full) ? S_ERROR : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    state_d = (!nack_q && reg_index_q == LAST_IDX) ? S_DONE : S_LOAD;
                end
            end
            S_DONE, S_ERROR: if (restart) state_d = S_LOAD;
            default:      state_d = S_POWER_WAIT;
        endcase
    end

    // Datapath: delay counter, retry bookkeeping, table index and write bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            retry_q     <= '0;
            nack_q      <= 1'b0;
            reg_index_q <= '0;
            tx_addr_q   <= '0;
            tx_data1_q  <= '0;
            tx_data2_q  <= '0;
        end else begin
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == S_POWER_WAIT || state_q == S_GAP) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == S_LOAD) begin
                tx_addr_q                <= DEV_ADDR;
                {tx_data1_q, tx_data2_q} <= table_word(reg_index_q);
            end

            if (txn_end) begin
                if (!txn_fail) begin
                    retry_q <= '0;
                    nack_q  <= 1'b0;
                end else if (!retry_full) begin
                    retry_q <= retry_q + 1'b1;
                    nack_q  <= 1'b1;
                end
            end

            if (state_q == S_GAP && state_d == S_LOAD && !nack_q) begin
                reg_index_q <= reg_index_q + 1'b1;
            end

            if ((state_q == S_DONE || state_q == S_ERROR) && restart) begin
                reg_index_q <= '0;
                retry_q     <= '0;
                nack_q      <= 1'b0;
            end
        end
    end

    // Outputs decoded from state.
    always_comb begin
        tx_req    = (state_q == S_REQ);
        busy      = !(state_q == S_DONE || state_q == S_ERROR);
        cfg_done  = (state_q == S_DONE);
        cfg_error = (state_q == S_ERROR);
    end

    assign tx_addr   = tx_addr_q;
    assign tx_data1  = tx_data1_q;
    assign tx_data2  = tx_data2_q;
    assign reg_index = reg_index_q;

endmodule
